// File: rtl/integer_multiplication_unit.sv
// Iterative radix-2 shift-add 32x32 multiplier (RV32M MUL/MULH/MULHSU/MULHU), 64-bit product.
// Optional early termination on an exhausted multiplier is enabled by defining MUL_EARLY_OUT_EN.
module integer_multiplication_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic [1:0]        op_i,
    input  logic [XLEN-1:0]   operand1_i,
    input  logic [XLEN-1:0]   operand2_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [2*XLEN-1:0] result_o,
    output logic [1:0]        state_o
);

    // Handshake: a request is accepted on any rising edge in IDLE with enable_i high; busy_o is
    // high for the whole CALC phase, done_o pulses for one cycle in DONE, and the inputs are
    // ignored from the accept edge until the FSM is back in IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [XLEN-1:0]     mcand;
    logic [XLEN-1:0]     mplier;
    logic [2*XLEN-1:0]   acc;
    logic [CNT_W-1:0]    cnt;
    logic                neg;
    logic [2*XLEN-1:0]   result_q;

    logic                sign1;
    logic                sign2;
    logic [XLEN-1:0]     mag1;
    logic [XLEN-1:0]     mag2;
    logic [XLEN:0]       sum;
    logic [2*XLEN-1:0]   acc_step;
    logic [2*XLEN-1:0]   acc_final;
    logic [2*XLEN-1:0]   result_next;
    logic                last_iter;
    logic                finish;

    always_comb begin
        sign1 = operand1_i[XLEN-1] & ((op_i == 2'b01) || (op_i == 2'b10));
        sign2 = operand2_i[XLEN-1] & (op_i == 2'b01);
        mag1  = sign1 ? (~operand1_i + 1'b1) : operand1_i;
        mag2  = sign2 ? (~operand2_i + 1'b1) : operand2_i;
    end

    // One iteration: conditional add at weight 2^XLEN, then shift {carry, acc} right by one.
    always_comb begin
        sum       = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (mplier[0] ? mcand : {XLEN{1'b0}})};
        acc_step  = {sum, acc[XLEN-1:1]};
        last_iter = (cnt == CNT_W'(XLEN - 1));
    end

`ifdef MUL_EARLY_OUT_EN
    logic [XLEN-1:0]  remain_mask;
    logic [CNT_W-1:0] shamt;
    logic             rest_zero;

    // The multiplier register also collects accumulator spill bits at the top, so only the
    // bits not yet consumed are examined; after this iteration they are all above bit 0.
    always_comb begin
        remain_mask = {XLEN{1'b1}} >> cnt;
        rest_zero   = (((mplier & remain_mask) >> 1) == {XLEN{1'b0}});
        shamt       = CNT_W'(XLEN - 1) - cnt;
        acc_final   = acc_step >> shamt;
        finish      = last_iter | rest_zero;
    end
`else
    always_comb begin
        acc_final = acc_step;
        finish    = last_iter;
    end
`endif

    always_comb begin
        result_next = neg ? (~acc_final + 1'b1) : acc_final;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable_i) state_next = CALC;
            CALC:    if (finish) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            result_q <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (enable_i) begin
                        mcand  <= mag1;
                        mplier <= mag2;
                        acc    <= '0;
                        cnt    <= '0;
                        neg    <= sign1 ^ sign2;
                    end
                end
                CALC: begin
                    acc    <= acc_step;
                    mplier <= {acc[0], mplier[XLEN-1:1]};
                    cnt    <= cnt + CNT_W'(1);
                    if (finish) result_q <= result_next;
                end
                default: ;
            endcase
        end
    end

    assign busy_o   = (state == CALC);
    assign done_o   = (state == DONE);
    assign result_o = result_q;
    assign state_o  = state;

endmodule

// File: tb/tb_integer_multiplication_unit.sv
// Directed self-checking bench for integer_multiplication_unit; latency expectations follow
// MUL_EARLY_OUT_EN when it is defined for the build.
module tb_integer_multiplication_unit;

`ifdef MUL_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic        enable_i;
    logic [1:0]  op_i;
    logic [31:0] operand1_i;
    logic [31:0] operand2_i;
    logic        busy_o;
    logic        done_o;
    logic [63:0] result_o;
    logic [1:0]  state_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    integer_multiplication_unit dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .enable_i   (enable_i),
        .op_i       (op_i),
        .operand1_i (operand1_i),
        .operand2_i (operand2_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .state_o    (state_o)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
        logic [31:0] m;
        int k;
        m = (op == 2'b01 && b[31]) ? (~b + 32'd1) : b;
        k = 0;
        for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
        if (!EARLY) return 32;
        return (k == 0) ? 1 : k;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle;
        int guard;
        guard = 0;
        while (state_o != 2'd0 && guard < 100) begin
            step();
            guard++;
        end
    endtask

    // Accepts one request and waits (bounded) for done_o; lat counts edges after the accept.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] res, output int lat, output logic busy_acc);
        wait_idle();
        op_i = op; operand1_i = a; operand2_i = b; enable_i = 1'b1;
        step();
        enable_i = 1'b0;
        busy_acc = busy_o;
        operand1_i = $urandom; operand2_i = $urandom; op_i = 2'($urandom_range(0, 3));
        lat = 0;
        while (!done_o && lat < 40) begin
            step();
            lat++;
        end
        res = result_o;
    endtask

    task automatic test_reset;
        rst_i = 1'b1; enable_i = 1'b0; op_i = 2'b00; operand1_i = '0; operand2_i = '0;
        step(); step();
        n_tests++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 64'd0 || state_o !== 2'd0) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b result=%h state=%0d, want 0 0 0 0",
                     busy_o, done_o, result_o, state_o);
        end
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_ops;
        vec_t vecs[13];
        logic [63:0] res;
        int lat;
        logic busy_acc;
        vecs = '{
            '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001},
            '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001},
            '{2'b01, 32'hFFFF_FFFF, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFF9},
            '{2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000},
            '{2'b10, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0002},
            '{2'b00, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000},
            '{2'b01, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000},
            '{2'b10, 32'h8000_0000, 32'h8000_0000, 64'hC000_0000_0000_0000},
            '{2'b01, 32'h0000_0005, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFF1},
            '{2'b01, 32'h1234_5678, 32'h0000_0000, 64'h0000_0000_0000_0000},
            '{2'b00, 32'h1234_5678, 32'h0000_0003, 64'h0000_0000_369D_0368},
            '{2'b10, 32'h0000_0007, 32'hFFFF_FFFF, 64'h0000_0006_FFFF_FFF9},
            '{2'b11, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000}
        };
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, busy_acc);
            n_tests++;
            if (busy_acc !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_after_accept[%0d]: got %b want 1", i, busy_acc);
            end
            n_tests++;
            if (res !== vecs[i].exp) begin
                n_fail++;
                $display("FAIL result[%0d] op=%b %h*%h: got %h want %h",
                         i, vecs[i].op, vecs[i].a, vecs[i].b, res, vecs[i].exp);
            end
            n_tests++;
            if (lat != exp_lat(vecs[i].op, vecs[i].b)) begin
                n_fail++;
                $display("FAIL latency[%0d]: got %0d want %0d", i, lat, exp_lat(vecs[i].op, vecs[i].b));
            end
            step(); step(); step();
            n_tests++;
            if (result_o !== vecs[i].exp || busy_o !== 1'b0 || done_o !== 1'b0) begin
                n_fail++;
                $display("FAIL hold[%0d]: result=%h busy=%b done=%b want %h 0 0",
                         i, result_o, busy_o, done_o, vecs[i].exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        logic both;
        wait_idle();
        both = 1'b0;
        op_i = 2'b00; operand1_i = 32'd3; operand2_i = 32'd5; enable_i = 1'b1;
        step();
        operand1_i = 32'd7; operand2_i = 32'd9;
        lat = 0;
        while (!done_o && lat < 40) begin
            step();
            lat++;
            if (busy_o && done_o) both = 1'b1;
        end
        n_tests++;
        if (result_o !== 64'd15 || lat != exp_lat(2'b00, 32'd5)) begin
            n_fail++;
            $display("FAIL b2b_first: result=%h lat=%0d want %h lat=%0d",
                     result_o, lat, 64'd15, exp_lat(2'b00, 32'd5));
        end
        step();
        n_tests++;
        if (state_o !== 2'd0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: state=%0d busy=%b done=%b want 0 0 0", state_o, busy_o, done_o);
        end
        step();
        enable_i = 1'b0;
        n_tests++;
        if (busy_o !== 1'b1 || result_o !== 64'd15) begin
            n_fail++;
            $display("FAIL b2b_second_accept: busy=%b result=%h want 1 %h", busy_o, result_o, 64'd15);
        end
        lat = 0;
        while (!done_o && lat < 40) begin
            step();
            lat++;
            if (busy_o && done_o) both = 1'b1;
        end
        n_tests++;
        if (result_o !== 64'd63 || lat != exp_lat(2'b00, 32'd9)) begin
            n_fail++;
            $display("FAIL b2b_second: result=%h lat=%0d want %h lat=%0d",
                     result_o, lat, 64'd63, exp_lat(2'b00, 32'd9));
        end
        n_tests++;
        if (both !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_busy_done_overlap: got %b want 0", both);
        end
    endtask

    task automatic test_reset_mid_calc;
        logic saw_done;
        wait_idle();
        op_i = 2'b11; operand1_i = 32'h1234_5678; operand2_i = 32'hFFFF_FFFF; enable_i = 1'b1;
        step();
        enable_i = 1'b0;
        repeat (9) step();
        rst_i = 1'b1;
        step();
        n_tests++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_mid_calc: busy=%b done=%b result=%h want 0 0 0",
                     busy_o, done_o, result_o);
        end
        rst_i = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done_o || busy_o) saw_done = 1'b1;
        end
        n_tests++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort_quiet: activity=%b want 0", saw_done);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        enable_i = 1'b0;
        op_i = 2'b00;
        operand1_i = '0;
        operand2_i = '0;
        test_reset();
        test_ops();
        test_back_to_back();
        test_reset_mid_calc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
